// File: rtl/hlink_rx_ctrl_pkg.sv
// Shared definitions for the hlink receive controller: default sizes and FSM encoding.
package hlink_rx_ctrl_pkg;

   // One activation word is 16 MACs x 8 bit.
   localparam int unsigned HLINK_CACHE_DATA_WIDTH = 128;
   localparam int unsigned HLINK_FIFO_DEPTH       = 4;
   localparam int unsigned HLINK_CNT_WIDTH        = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRecv  = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } hlink_rx_state_e;

endpackage

// File: rtl/hlink_fwft_fifo.sv
// Synchronous first-word-fall-through buffer. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate counter.
module hlink_fwft_fifo #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW:0]    wr_ptr_q;
   logic [PtrW:0]    rd_ptr_q;
   logic             push_ok;
   logic             pop_ok;

   // Status flags and guarded push/pop; a push into a full buffer is allowed only when a
   // pop frees the head slot in the same cycle.
   always_comb begin
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
      level   = wr_ptr_q - rd_ptr_q;
      pop_ok  = pop && !empty;
      push_ok = push && (!full || pop_ok);
      rdata   = empty ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];
   end

   // Storage and pointer update; reset clears stored words so nothing stale survives.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
            wr_ptr_q                  <= wr_ptr_q + (PtrW+1)'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/hlink_rx_ctrl.sv
// Receive controller for one inter-core link hop: counts a configured number of words,
// buffers them for the local MAC array and optionally forwards them to the next core.
module hlink_rx_ctrl
   import hlink_rx_ctrl_pkg::*;
#(
   parameter int unsigned CACHE_DATA_WIDTH = HLINK_CACHE_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH       = HLINK_FIFO_DEPTH,
   parameter int unsigned CNT_WIDTH        = HLINK_CNT_WIDTH
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        start,
   input  logic [CNT_WIDTH-1:0]        cfg_word_num,
   input  logic                        cfg_fwd_en,
   input  logic [CACHE_DATA_WIDTH-1:0] in_rdata,
   input  logic                        in_rvalid,
   output logic [CACHE_DATA_WIDTH-1:0] fwd_wdata,
   output logic                        fwd_wen,
   output logic [CACHE_DATA_WIDTH-1:0] act_data,
   output logic                        act_valid,
   input  logic                        act_ready,
   output logic                        busy,
   output logic                        done,
   output logic                        ovf_err
);

   localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

   hlink_rx_state_e             state_q, state_d;
   logic [CNT_WIDTH-1:0]        word_num_q, word_num_d;
   logic                        fwd_en_q, fwd_en_d;
   logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]        cnt_inc;
   logic                        ovf_q, ovf_d;
   logic                        fwd_wen_q;
   logic [CACHE_DATA_WIDTH-1:0] fwd_wdata_q;

   logic                        rx_word;
   logic                        fifo_push;
   logic                        fifo_pop;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [LvlW-1:0]             fifo_level;
   logic                        drop;

   hlink_fwft_fifo #(
      .WIDTH (CACHE_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (fifo_push),
      .wdata (in_rdata),
      .pop   (fifo_pop),
      .rdata (act_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Word acceptance: only RECV takes words; a word that finds the buffer full with no
   // pop this cycle is dropped but still counted and forwarded.
   always_comb begin
      rx_word   = (state_q == StRecv) && in_rvalid;
      fifo_pop  = !fifo_empty && act_ready;
      fifo_push = rx_word && (!fifo_full || fifo_pop);
      drop      = rx_word && fifo_full && !fifo_pop;
      cnt_inc   = cnt_q + CNT_WIDTH'(1);
   end

   // Next-state logic and configuration/counter updates.
   always_comb begin
      state_d    = state_q;
      word_num_d = word_num_q;
      fwd_en_d   = fwd_en_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q || drop;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               word_num_d = cfg_word_num;
               fwd_en_d   = cfg_fwd_en;
               cnt_d      = '0;
               ovf_d      = 1'b0;
               state_d    = (cfg_word_num == '0) ? StDone : StRecv;
            end
         end
         StRecv: begin
            if (in_rvalid) begin
               cnt_d = cnt_inc;
               if (cnt_inc == word_num_q) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            // Leave as the last word is popped so DONE coincides with the buffer going empty.
            if (fifo_empty || (fifo_pop && (fifo_level == LvlW'(1)))) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, latched configuration, counter and sticky overflow flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         word_num_q <= '0;
         fwd_en_q   <= 1'b0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_num_q <= word_num_d;
         fwd_en_q   <= fwd_en_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   // Forward path: one-cycle registered copy of accepted words toward the next core.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fwd_wen_q   <= 1'b0;
         fwd_wdata_q <= '0;
      end else begin
         fwd_wen_q <= rx_word && fwd_en_q;
         if (rx_word && fwd_en_q) begin
            fwd_wdata_q <= in_rdata;
         end
      end
   end

   // Output decode; ovf_err also reflects a drop in the current cycle.
   always_comb begin
      fwd_wen   = fwd_wen_q;
      fwd_wdata = fwd_wdata_q;
      act_valid = !fifo_empty;
      busy      = (state_q == StRecv) || (state_q == StDrain);
      done      = (state_q == StDone);
      ovf_err   = ovf_q || drop;
   end

endmodule

// File: doc/hlink_rx_ctrl.md
HLINK_RX_CTRL -- requirements
Module: hlink_rx_ctrl

Interface
REQ-001 Parameter CACHE_DATA_WIDTH, default 128, width of one activation word (16 MACs x 8-bit).
REQ-002 Parameter FIFO_DEPTH, default 4, local buffer depth in words; power of two, >= 2.
REQ-003 Parameter CNT_WIDTH, default 8, width of the word-count configuration and counters.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle pulse that begins one receive transaction.
REQ-007 cfg_word_num  input  CNT_WIDTH  number of words to receive; sampled on accepted start.
REQ-008 cfg_fwd_en  input  1  forward received words to the next core; sampled on accepted start.
REQ-009 in_rdata  input  CACHE_DATA_WIDTH  word from the upstream core link register.
REQ-010 in_rvalid  input  1  in_rdata valid this cycle; no backpressure exists toward upstream.
REQ-011 fwd_wdata  output  CACHE_DATA_WIDTH  word forwarded to the next core's link write port.
REQ-012 fwd_wen  output  1  write enable for fwd_wdata.
REQ-013 act_data  output  CACHE_DATA_WIDTH  head-of-buffer word to the local MAC array.
REQ-014 act_valid  output  1  act_data valid.
REQ-015 act_ready  input  1  local consumer accepts act_data when act_valid & act_ready.
REQ-016 busy  output  1  high in RECV and DRAIN.
REQ-017 done  output  1  single-cycle pulse when the transaction completes.
REQ-018 ovf_err  output  1  sticky: a word was dropped because the buffer was full.

Function
REQ-019 The FSM SHALL have states IDLE, RECV, DRAIN and DONE.
REQ-020 IDLE: start with cfg_word_num != 0 SHALL latch the config, clear the counter and ovf_err, and enter RECV next cycle.
REQ-021 IDLE: start with cfg_word_num == 0 SHALL go to DONE without receiving any word.
REQ-022 start in any state other than IDLE SHALL be ignored.
REQ-023 RECV: each in_rvalid cycle SHALL count as one received word; on the cycle the count reaches cfg_word_num the FSM SHALL go to DRAIN.
REQ-024 in_rvalid outside RECV SHALL be ignored: no store, no forward, no count.
REQ-025 A received word SHALL be written to the buffer unless it is full with no pop in the same cycle; if full with a simultaneous pop, the write SHALL succeed.
REQ-026 A received word that cannot be written SHALL be dropped and SHALL set ovf_err; it SHALL still be counted and forwarded.
REQ-027 Buffer is first-word-fall-through: a word written at edge k SHALL appear on act_data with act_valid=1 in cycle k+1.
REQ-028 act_valid SHALL equal buffer-not-empty; a pop SHALL occur on act_valid & act_ready.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-030 When fwd_en is latched, fwd_wen/fwd_wdata SHALL be registered copies of in_rvalid/in_rdata for words accepted in RECV (latency 1); otherwise fwd_wen SHALL stay 0.
REQ-031 DRAIN SHALL go to DONE on the first cycle the buffer is empty; DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-032 ovf_err SHALL hold until the next accepted start.

Reset
REQ-033 On rstn low the block SHALL enter IDLE and clear pointers, counter, buffer storage and latched config.
REQ-034 During and after reset, fwd_wdata, fwd_wen, act_data, act_valid, busy, done and ovf_err SHALL all be 0.
REQ-035 Reset mid-transaction SHALL discard all buffered words without asserting done.

Structure
REQ-036 State encoding and the default CACHE_DATA_WIDTH/FIFO_DEPTH/CNT_WIDTH constants SHALL live in the shared core package.
REQ-037 The buffer SHALL be a sub-module hlink_fwft_fifo (sync, FWFT, push/pop/full/empty).

Verification
REQ-038 start, N=3, fwd_en=1, words A,B,C on consecutive cycles, act_ready=1 -> fwd_wen on 3 cycles each 1 cycle late; act_data A,B,C; done 1 cycle after the last pop.
REQ-039 N=6, act_ready=0, 6 back-to-back words, depth 4 -> first 4 stored; ovf_err=1 from the 5th word's cycle; all 6 forwarded; FSM stays in DRAIN until 4 pops.
REQ-040 Buffer full and in_rvalid with act_ready=1 in the same cycle -> no drop, ovf_err stays 0, occupancy stays 4.
REQ-041 start with N=0 -> done pulse 1 cycle later; busy never asserts; fwd_wen stays 0.
REQ-042 in_rvalid in IDLE, and start during RECV -> no store or forward; latched N unchanged.
REQ-043 rstn asserted in RECV with 2 words buffered -> all outputs 0 immediately; after release act_valid=0 and state is IDLE.
